// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit bus CPU: opcodes, micro-step encodings and the
// control-word layout driven onto the bus control lines.
package cpu_pkg;

  localparam int unsigned OpcodeWidth = 4;
  localparam int unsigned StepWidth   = 3;

  localparam logic [OpcodeWidth-1:0] OP_NOP = 4'b0000;
  localparam logic [OpcodeWidth-1:0] OP_LDA = 4'b0001;
  localparam logic [OpcodeWidth-1:0] OP_ADD = 4'b0010;
  localparam logic [OpcodeWidth-1:0] OP_SUB = 4'b0011;
  localparam logic [OpcodeWidth-1:0] OP_STA = 4'b0100;
  localparam logic [OpcodeWidth-1:0] OP_LDI = 4'b0101;
  localparam logic [OpcodeWidth-1:0] OP_JMP = 4'b0110;
  localparam logic [OpcodeWidth-1:0] OP_JC  = 4'b0111;
  localparam logic [OpcodeWidth-1:0] OP_JZ  = 4'b1000;
  localparam logic [OpcodeWidth-1:0] OP_OUT = 4'b1110;
  localparam logic [OpcodeWidth-1:0] OP_HLT = 4'b1111;

  // Encodings double as the debug step display, so HALT sits at 7.
  typedef enum logic [StepWidth-1:0] {
    StT0   = 3'd0,
    StT1   = 3'd1,
    StT2   = 3'd2,
    StT3   = 3'd3,
    StT4   = 3'd4,
    StHalt = 3'd7
  } step_e;

  typedef struct packed {
    logic pc_inc;
    logic pc_out;
    logic jmp;
    logic mar_in;
    logic ram_in;
    logic ram_out;
    logic ir_in;
    logic ir_out;
    logic a_in;
    logic a_out;
    logic b_in;
    logic alu_out;
    logic sub;
    logic flags_in;
    logic out_in;
  } ctrl_word_t;

  localparam ctrl_word_t CtrlNone = '0;

endpackage

// File: rtl/control_rom.sv
// Combinational micro-code table: maps the current micro-step, opcode and flags to the
// control word plus the end-of-instruction and enter-halt indications.
module control_rom
  import cpu_pkg::*;
(
  input  step_e            step,
  input  logic [3:0]       opcode,
  input  logic             carry_flag,
  input  logic             zero_flag,
  output ctrl_word_t       ctrl,
  output logic             last_step,
  output logic             to_halt
);

  always_comb begin
    ctrl      = CtrlNone;
    last_step = 1'b0;
    to_halt   = 1'b0;

    unique case (step)
      StT0: begin
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
      end

      StT1: begin
        ctrl.ram_out = 1'b1;
        ctrl.ir_in   = 1'b1;
        ctrl.pc_inc  = 1'b1;
      end

      StT2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl.ir_out = 1'b1;
            ctrl.mar_in = 1'b1;
          end
          OP_LDI: begin
            ctrl.ir_out = 1'b1;
            ctrl.a_in   = 1'b1;
            last_step   = 1'b1;
          end
          OP_JMP: begin
            ctrl.ir_out = 1'b1;
            ctrl.jmp    = 1'b1;
            last_step   = 1'b1;
          end
          OP_JC: begin
            ctrl.ir_out = carry_flag;
            ctrl.jmp    = carry_flag;
            last_step   = 1'b1;
          end
          OP_JZ: begin
            ctrl.ir_out = zero_flag;
            ctrl.jmp    = zero_flag;
            last_step   = 1'b1;
          end
          OP_OUT: begin
            ctrl.a_out  = 1'b1;
            ctrl.out_in = 1'b1;
            last_step   = 1'b1;
          end
          OP_HLT: begin
            to_halt = 1'b1;
          end
          // OP_NOP and the unassigned 1001-1101 codes.
          default: begin
            last_step = 1'b1;
          end
        endcase
      end

      StT3: begin
        case (opcode)
          OP_LDA: begin
            ctrl.ram_out = 1'b1;
            ctrl.a_in    = 1'b1;
            last_step    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl.ram_out = 1'b1;
            ctrl.b_in    = 1'b1;
          end
          OP_STA: begin
            ctrl.a_out  = 1'b1;
            ctrl.ram_in = 1'b1;
            last_step   = 1'b1;
          end
          default: begin
            last_step = 1'b1;
          end
        endcase
      end

      StT4: begin
        case (opcode)
          OP_ADD, OP_SUB: begin
            ctrl.alu_out  = 1'b1;
            ctrl.a_in     = 1'b1;
            ctrl.flags_in = 1'b1;
            ctrl.sub      = (opcode == OP_SUB);
          end
          default: ;
        endcase
        last_step = 1'b1;
      end

      StHalt: ;

      // Unused encodings fall back to fetch rather than wedging the sequencer.
      default: begin
        last_step = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Micro-step sequencer for the 4-bit bus CPU: owns the step register, applies run/clear
// gating and fans the control word out onto the individual bus control lines.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic       clock,
  input  logic       clear,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       carry_flag,
  input  logic       zero_flag,
  output logic       pc_inc,
  output logic       pc_out,
  output logic       jmp,
  output logic       mar_in,
  output logic       ram_in,
  output logic       ram_out,
  output logic       ir_in,
  output logic       ir_out,
  output logic       a_in,
  output logic       a_out,
  output logic       b_in,
  output logic       alu_out,
  output logic       sub,
  output logic       flags_in,
  output logic       out_in,
  output logic       halt,
  output logic [2:0] step
);

  step_e      step_q, step_d;
  ctrl_word_t rom_ctrl;
  ctrl_word_t ctrl_out;
  logic       rom_last_step;
  logic       rom_to_halt;

  control_rom u_control_rom (
    .step       (step_q),
    .opcode     (opcode),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .ctrl       (rom_ctrl),
    .last_step  (rom_last_step),
    .to_halt    (rom_to_halt)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      step_q <= StT0;
    end else begin
      step_q <= step_d;
    end
  end

  always_comb begin
    step_d = step_q;
    if (run && (step_q != StHalt)) begin
      if (rom_to_halt) begin
        step_d = StHalt;
      end else if (rom_last_step) begin
        step_d = StT0;
      end else begin
        step_d = step_e'(step_q + 3'd1);
      end
    end
  end

  // Forcing the word to zero while clear is high keeps the aborted instruction from
  // writing anything on the clear edge.
  always_comb begin
    ctrl_out = CtrlNone;
    if (run && !clear && (step_q != StHalt)) begin
      ctrl_out = rom_ctrl;
    end
    halt = !clear && (step_q == StHalt);
    step = clear ? 3'd0 : step_q;
  end

  assign pc_inc   = ctrl_out.pc_inc;
  assign pc_out   = ctrl_out.pc_out;
  assign jmp      = ctrl_out.jmp;
  assign mar_in   = ctrl_out.mar_in;
  assign ram_in   = ctrl_out.ram_in;
  assign ram_out  = ctrl_out.ram_out;
  assign ir_in    = ctrl_out.ir_in;
  assign ir_out   = ctrl_out.ir_out;
  assign a_in     = ctrl_out.a_in;
  assign a_out    = ctrl_out.a_out;
  assign b_in     = ctrl_out.b_in;
  assign alu_out  = ctrl_out.alu_out;
  assign sub      = ctrl_out.sub;
  assign flags_in = ctrl_out.flags_in;
  assign out_in   = ctrl_out.out_in;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a vector table for the main sequences, an
// independent micro-code model for the opcode/flag sweep, and a queue-based scoreboard.
module tb_control_sequencer;

  logic       clock;
  logic       clear;
  logic       run;
  logic [3:0] opcode;
  logic       carry_flag;
  logic       zero_flag;
  logic       pc_inc, pc_out, jmp, mar_in, ram_in, ram_out, ir_in, ir_out;
  logic       a_in, a_out, b_in, alu_out, sub, flags_in, out_in;
  logic       halt;
  logic [2:0] step;

  control_sequencer dut (
    .clock      (clock),
    .clear      (clear),
    .run        (run),
    .opcode     (opcode),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .pc_inc     (pc_inc),
    .pc_out     (pc_out),
    .jmp        (jmp),
    .mar_in     (mar_in),
    .ram_in     (ram_in),
    .ram_out    (ram_out),
    .ir_in      (ir_in),
    .ir_out     (ir_out),
    .a_in       (a_in),
    .a_out      (a_out),
    .b_in       (b_in),
    .alu_out    (alu_out),
    .sub        (sub),
    .flags_in   (flags_in),
    .out_in     (out_in),
    .halt       (halt),
    .step       (step)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bit positions in the order the control lines are listed in the interface.
  localparam logic [14:0] W_PC_INC   = 15'h4000;
  localparam logic [14:0] W_PC_OUT   = 15'h2000;
  localparam logic [14:0] W_JMP      = 15'h1000;
  localparam logic [14:0] W_MAR_IN   = 15'h0800;
  localparam logic [14:0] W_RAM_IN   = 15'h0400;
  localparam logic [14:0] W_RAM_OUT  = 15'h0200;
  localparam logic [14:0] W_IR_IN    = 15'h0100;
  localparam logic [14:0] W_IR_OUT   = 15'h0080;
  localparam logic [14:0] W_A_IN     = 15'h0040;
  localparam logic [14:0] W_A_OUT    = 15'h0020;
  localparam logic [14:0] W_B_IN     = 15'h0010;
  localparam logic [14:0] W_ALU_OUT  = 15'h0008;
  localparam logic [14:0] W_SUB      = 15'h0004;
  localparam logic [14:0] W_FLAGS_IN = 15'h0002;
  localparam logic [14:0] W_OUT_IN   = 15'h0001;
  localparam logic [14:0] F0 = W_PC_OUT | W_MAR_IN;
  localparam logic [14:0] F1 = W_RAM_OUT | W_IR_IN | W_PC_INC;

  typedef struct {
    logic       clr;
    logic       rn;
    logic [3:0] op;
    logic       c;
    logic       z;
    logic [2:0] step;
    logic       halt;
    logic [14:0] word;
  } vec_t;

  typedef struct {
    logic [2:0]  step;
    logic        halt;
    logic [14:0] word;
    string       name;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic clr, logic rn, logic [3:0] op, logic c, logic z,
                              logic [2:0] st, logic hl, logic [14:0] w);
    vec_t v;
    v.clr = clr; v.rn = rn; v.op = op; v.c = c; v.z = z;
    v.step = st; v.halt = hl; v.word = w;
    return v;
  endfunction

  function automatic logic [14:0] model_word(int s, logic [3:0] op, logic c, logic z);
    logic [14:0] w;
    w = '0;
    case (s)
      0: w = F0;
      1: w = F1;
      2: case (op)
        4'd1, 4'd2, 4'd3, 4'd4: w = W_IR_OUT | W_MAR_IN;
        4'd5:  w = W_IR_OUT | W_A_IN;
        4'd6:  w = W_IR_OUT | W_JMP;
        4'd7:  w = c ? (W_IR_OUT | W_JMP) : 15'h0;
        4'd8:  w = z ? (W_IR_OUT | W_JMP) : 15'h0;
        4'd14: w = W_A_OUT | W_OUT_IN;
        default: w = '0;
      endcase
      3: case (op)
        4'd1:       w = W_RAM_OUT | W_A_IN;
        4'd2, 4'd3: w = W_RAM_OUT | W_B_IN;
        4'd4:       w = W_A_OUT | W_RAM_IN;
        default:    w = '0;
      endcase
      4: case (op)
        4'd2:    w = W_ALU_OUT | W_A_IN | W_FLAGS_IN;
        4'd3:    w = W_ALU_OUT | W_A_IN | W_FLAGS_IN | W_SUB;
        default: w = '0;
      endcase
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic int model_last(logic [3:0] op);
    case (op)
      4'd1, 4'd4: return 3;
      4'd2, 4'd3: return 4;
      default:    return 2;
    endcase
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare mid-cycle, then advance.
  task automatic apply(input logic clr, input logic rn, input logic [3:0] op, input logic c,
                       input logic z, input logic [2:0] st, input logic hl,
                       input logic [14:0] w, input string name);
    exp_t e;
    exp_t got;
    logic [14:0] act;
    clear = clr; run = rn; opcode = op; carry_flag = c; zero_flag = z;
    e.step = st; e.halt = hl; e.word = w; e.name = name;
    exp_q.push_back(e);
    @(negedge clock);
    act = {pc_inc, pc_out, jmp, mar_in, ram_in, ram_out, ir_in, ir_out,
           a_in, a_out, b_in, alu_out, sub, flags_in, out_in};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty at sample time", name);
    end else begin
      got = exp_q.pop_front();
      if (step !== got.step || halt !== got.halt || act !== got.word) begin
        errors++;
        $display("FAIL %s: got step=%0d halt=%0b word=%h, expected step=%0d halt=%0b word=%h",
                 got.name, step, halt, act, got.step, got.halt, got.word);
      end
    end
    checks++;
    if ($countones({pc_out, ram_out, ir_out, a_out, alu_out}) > 1) begin
      errors++;
      $display("FAIL %s bus_drivers: got %b, expected at most one set", name,
               {pc_out, ram_out, ir_out, a_out, alu_out});
    end
    checks++;
    if (pc_inc && jmp) begin
      errors++;
      $display("FAIL %s pc_inc_jmp: got pc_inc=1 jmp=1, expected not both", name);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    int lat;
    logic c;
    logic z;

    clear = 1'b1; run = 1'b1; opcode = 4'd0; carry_flag = 1'b0; zero_flag = 1'b0;

    // Reset and ADD
    vecs.push_back(mk(1, 1, 4'd0, 0, 0, 3'd0, 0, 15'h0));
    vecs.push_back(mk(1, 1, 4'd0, 0, 0, 3'd0, 0, 15'h0));
    vecs.push_back(mk(0, 1, 4'd2, 0, 0, 3'd0, 0, F0));
    vecs.push_back(mk(0, 1, 4'd2, 0, 0, 3'd1, 0, F1));
    vecs.push_back(mk(0, 1, 4'd2, 0, 0, 3'd2, 0, W_IR_OUT | W_MAR_IN));
    vecs.push_back(mk(0, 1, 4'd2, 0, 0, 3'd3, 0, W_RAM_OUT | W_B_IN));
    vecs.push_back(mk(0, 1, 4'd2, 0, 0, 3'd4, 0, W_ALU_OUT | W_A_IN | W_FLAGS_IN));
    // JC not taken, then taken
    vecs.push_back(mk(0, 1, 4'd7, 0, 0, 3'd0, 0, F0));
    vecs.push_back(mk(0, 1, 4'd7, 0, 0, 3'd1, 0, F1));
    vecs.push_back(mk(0, 1, 4'd7, 0, 0, 3'd2, 0, 15'h0));
    vecs.push_back(mk(0, 1, 4'd7, 1, 0, 3'd0, 0, F0));
    vecs.push_back(mk(0, 1, 4'd7, 1, 0, 3'd1, 0, F1));
    vecs.push_back(mk(0, 1, 4'd7, 1, 0, 3'd2, 0, W_IR_OUT | W_JMP));
    // JZ ignores carry, follows zero
    vecs.push_back(mk(0, 1, 4'd8, 1, 0, 3'd0, 0, F0));
    vecs.push_back(mk(0, 1, 4'd8, 1, 0, 3'd1, 0, F1));
    vecs.push_back(mk(0, 1, 4'd8, 1, 0, 3'd2, 0, 15'h0));
    vecs.push_back(mk(0, 1, 4'd8, 0, 1, 3'd0, 0, F0));
    vecs.push_back(mk(0, 1, 4'd8, 0, 1, 3'd1, 0, F1));
    vecs.push_back(mk(0, 1, 4'd8, 0, 1, 3'd2, 0, W_IR_OUT | W_JMP));
    // SUB
    vecs.push_back(mk(0, 1, 4'd3, 0, 0, 3'd0, 0, F0));
    vecs.push_back(mk(0, 1, 4'd3, 0, 0, 3'd1, 0, F1));
    vecs.push_back(mk(0, 1, 4'd3, 0, 0, 3'd2, 0, W_IR_OUT | W_MAR_IN));
    vecs.push_back(mk(0, 1, 4'd3, 0, 0, 3'd3, 0, W_RAM_OUT | W_B_IN));
    vecs.push_back(mk(0, 1, 4'd3, 0, 0, 3'd4, 0, W_ALU_OUT | W_A_IN | W_FLAGS_IN | W_SUB));
    // LDA frozen entering T3
    vecs.push_back(mk(0, 1, 4'd1, 0, 0, 3'd0, 0, F0));
    vecs.push_back(mk(0, 1, 4'd1, 0, 0, 3'd1, 0, F1));
    vecs.push_back(mk(0, 1, 4'd1, 0, 0, 3'd2, 0, W_IR_OUT | W_MAR_IN));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 4'd1, 0, 0, 3'd3, 0, 15'h0));
    vecs.push_back(mk(0, 1, 4'd1, 0, 0, 3'd3, 0, W_RAM_OUT | W_A_IN));
    // ADD aborted by clear in T3
    vecs.push_back(mk(0, 1, 4'd2, 0, 0, 3'd0, 0, F0));
    vecs.push_back(mk(0, 1, 4'd2, 0, 0, 3'd1, 0, F1));
    vecs.push_back(mk(0, 1, 4'd2, 0, 0, 3'd2, 0, W_IR_OUT | W_MAR_IN));
    vecs.push_back(mk(1, 1, 4'd2, 0, 0, 3'd0, 0, 15'h0));
    // HLT
    vecs.push_back(mk(0, 1, 4'd15, 0, 0, 3'd0, 0, F0));
    vecs.push_back(mk(0, 1, 4'd15, 0, 0, 3'd1, 0, F1));
    vecs.push_back(mk(0, 1, 4'd15, 0, 0, 3'd2, 0, 15'h0));

    @(posedge clock);
    #1;
    foreach (vecs[i]) begin
      apply(vecs[i].clr, vecs[i].rn, vecs[i].op, vecs[i].c, vecs[i].z,
            vecs[i].step, vecs[i].halt, vecs[i].word, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 20; i++) apply(0, 1, 4'd15, 0, 0, 3'd7, 1, 15'h0, "halt_hold");
    apply(1, 1, 4'd15, 0, 0, 3'd0, 0, 15'h0, "halt_clear");

    // Sweep every opcode under every flag combination; also checks fetch-to-fetch latency.
    for (int op = 0; op < 16; op++) begin
      for (int cz = 0; cz < 4; cz++) begin
        c = cz[1];
        z = cz[0];
        s = 0;
        lat = 0;
        do begin
          apply(0, 1, op[3:0], c, z, s[2:0], 0, model_word(s, op[3:0], c, z),
                $sformatf("sweep_op%0d_cz%0d_t%0d", op, cz, s));
          lat++;
          if (s == 2 && op == 15) s = 7;
          else if (s == model_last(op[3:0])) s = 0;
          else s++;
        end while (s != 0 && s != 7 && lat < 8);
        if (op == 15) begin
          apply(0, 1, 4'd15, c, z, 3'd7, 1, 15'h0, "sweep_halt");
          apply(1, 1, 4'd15, c, z, 3'd0, 0, 15'h0, "sweep_halt_clear");
        end else begin
          checks++;
          if (lat != model_last(op[3:0]) + 1) begin
            errors++;
            $display("FAIL latency_op%0d: got %0d cycles, expected %0d", op, lat,
                     model_last(op[3:0]) + 1);
          end
        end
      end
    end

    apply(0, 1, 4'd0, 0, 0, 3'd0, 0, F0, "final_fetch");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
